// File: rtl/up_tpl_pn_cnt_pkg.sv
// Shared constants for the TPL PN error counter register window:
// register offsets, version word and per-channel flag bit positions.
package up_tpl_pn_cnt_pkg;

  localparam logic [7:0]  OFF_CONFIG   = 8'h00;
  localparam logic [7:0]  OFF_CONTROL  = 8'h01;
  localparam logic [7:0]  OFF_SUMMARY  = 8'h02;
  localparam logic [7:0]  OFF_IRQ_MASK = 8'h03;
  localparam logic [7:0]  CH_BASE      = 8'h10;
  localparam int          CH_STRIDE    = 2;

  localparam logic [15:0] VERSION      = 16'h0001;

  localparam int FLAG_ERR_SEEN = 0;
  localparam int FLAG_OOS_SEEN = 1;
  localparam int FLAG_OOS_LIVE = 2;

  // COUNT register offset of a channel; its FLAGS register sits at +1.
  function automatic int ch_count_off(input int ch);
    return int'(CH_BASE) + CH_STRIDE * ch;
  endfunction

endpackage

// File: rtl/up_tpl_pn_err_cnt_if.sv
// up_* register bus: write and read request channels with one-cycle acks.
// A request is taken on every cycle its req is high; ack pulses one cycle later.
interface up_tpl_pn_err_cnt_if;
  logic        up_wreq;
  logic [9:0]  up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;
  logic        up_rreq;
  logic [9:0]  up_raddr;
  logic [31:0] up_rdata;
  logic        up_rack;

  modport master (
    output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    input  up_wack, up_rdata, up_rack
  );

  modport slave (
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    output up_wack, up_rdata, up_rack
  );
endinterface

// File: rtl/up_tpl_pn_cnt_channel.sv
// One monitored PN channel: saturating live error counter, snapshot copy,
// and W1C sticky ERR_SEEN / OOS_SEEN flags plus the live OOS level.
module up_tpl_pn_cnt_channel
  import up_tpl_pn_cnt_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pn_err_i,
  input  logic                 pn_oos_i,
  input  logic                 snap_i,
  input  logic                 clr_i,
  input  logic [1:0]           w1c_i,
  output logic [CNT_WIDTH-1:0] snap_o,
  output logic [2:0]           flags_o
);

  logic [CNT_WIDTH-1:0] live_q, live_d;
  logic [CNT_WIDTH-1:0] snap_q, snap_d;
  logic                 err_seen_q, err_seen_d;
  logic                 oos_seen_q, oos_seen_d;

  // Snapshot samples live_q, so it sees the value before this cycle's clear/increment.
  always_comb begin
    live_d = live_q;
    if (clr_i) begin
      live_d = '0;
    end else if (pn_err_i && !pn_oos_i && (live_q != '1)) begin
      live_d = live_q + 1'b1;
    end
    snap_d     = snap_i ? live_q : snap_q;
    err_seen_d = pn_err_i | (err_seen_q & ~w1c_i[FLAG_ERR_SEEN]);
    oos_seen_d = pn_oos_i | (oos_seen_q & ~w1c_i[FLAG_OOS_SEEN]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live_q     <= '0;
      snap_q     <= '0;
      err_seen_q <= 1'b0;
      oos_seen_q <= 1'b0;
    end else begin
      live_q     <= live_d;
      snap_q     <= snap_d;
      err_seen_q <= err_seen_d;
      oos_seen_q <= oos_seen_d;
    end
  end

  always_comb begin
    flags_o                = '0;
    flags_o[FLAG_ERR_SEEN] = err_seen_q;
    flags_o[FLAG_OOS_SEEN] = oos_seen_q;
    flags_o[FLAG_OOS_LIVE] = pn_oos_i;
  end

  assign snap_o = snap_q;

endmodule

// File: rtl/up_tpl_pn_err_cnt.sv
// PN error counter register window: decode, read mux, acks and optional irq.
// Optional interrupt logic is built only when UP_TPL_PN_CNT_IRQ_EN is defined.
module up_tpl_pn_err_cnt
  import up_tpl_pn_cnt_pkg::*;
#(
  parameter int         NUM_CHANNELS = 4,
  parameter int         CNT_WIDTH    = 32,
  parameter logic [9:0] BASE_ADDR    = 10'h300
) (
  input  logic                    up_clk,
  input  logic                    up_rst,
  input  logic [NUM_CHANNELS-1:0] pn_err,
  input  logic [NUM_CHANNELS-1:0] pn_oos,
  up_tpl_pn_err_cnt_if.slave      up_bus,
  output logic                    irq
);

  logic       w_hit, r_hit;
  logic [7:0] w_off, r_off;
  logic       snap_all, clr_all;

  logic [CNT_WIDTH-1:0]    snap_w  [NUM_CHANNELS];
  logic [2:0]              flags_w [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] err_seen_v, oos_seen_v;
  logic [1:0]              summary;

  logic        wack_q, rack_q;
  logic [31:0] rdata_q, rdata_d;
  logic        unused_wdata;

  assign w_hit = up_bus.up_wreq && (up_bus.up_waddr[9:8] == BASE_ADDR[9:8]);
  assign r_hit = up_bus.up_rreq && (up_bus.up_raddr[9:8] == BASE_ADDR[9:8]);
  assign w_off = up_bus.up_waddr[7:0];
  assign r_off = up_bus.up_raddr[7:0];

  assign snap_all     = w_hit && (w_off == OFF_CONTROL) && up_bus.up_wdata[0];
  assign clr_all      = w_hit && (w_off == OFF_CONTROL) && up_bus.up_wdata[1];
  assign unused_wdata = ^up_bus.up_wdata[31:2];

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic [1:0] w1c;
    assign w1c = (w_hit && (int'(w_off) == ch_count_off(g) + 1)) ?
                 up_bus.up_wdata[1:0] : 2'b00;

    up_tpl_pn_cnt_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk_i    (up_clk),
      .rst_i    (up_rst),
      .pn_err_i (pn_err[g]),
      .pn_oos_i (pn_oos[g]),
      .snap_i   (snap_all),
      .clr_i    (clr_all),
      .w1c_i    (w1c),
      .snap_o   (snap_w[g]),
      .flags_o  (flags_w[g])
    );

    assign err_seen_v[g] = flags_w[g][FLAG_ERR_SEEN];
    assign oos_seen_v[g] = flags_w[g][FLAG_OOS_SEEN];
  end

  assign summary = {|oos_seen_v, |err_seen_v};

`ifdef UP_TPL_PN_CNT_IRQ_EN
  logic [1:0] mask_q, mask_d;
  logic       irq_q, irq_d;

  // irq follows the already-registered flags, hence two cycles from pn_err.
  always_comb begin
    mask_d = mask_q;
    if (w_hit && (w_off == OFF_IRQ_MASK)) mask_d = up_bus.up_wdata[1:0];
    irq_d = |(summary & mask_q);
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      mask_q <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_d = '0;
    case (r_off)
      OFF_CONFIG:   rdata_d = {VERSION, 8'(CNT_WIDTH), 8'(NUM_CHANNELS)};
      OFF_SUMMARY:  rdata_d = {30'b0, summary};
`ifdef UP_TPL_PN_CNT_IRQ_EN
      OFF_IRQ_MASK: rdata_d = {30'b0, mask_q};
`endif
      default: begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (int'(r_off) == ch_count_off(i))     rdata_d[CNT_WIDTH-1:0] = snap_w[i];
          if (int'(r_off) == ch_count_off(i) + 1) rdata_d[2:0]           = flags_w[i];
        end
      end
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      wack_q  <= 1'b0;
      rack_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      wack_q  <= w_hit;
      rack_q  <= r_hit;
      rdata_q <= r_hit ? rdata_d : 32'h0;
    end
  end

  assign up_bus.up_wack  = wack_q;
  assign up_bus.up_rack  = rack_q;
  assign up_bus.up_rdata = rdata_q;

endmodule

// File: tb/tb_up_tpl_pn_err_cnt.sv
// Bench for up_tpl_pn_err_cnt: directed steps plus a random phase, all checked
// against a per-channel count/flag model of the register window.
module tb_up_tpl_pn_err_cnt;

  localparam int         NCH     = 4;
  localparam int         CW      = 32;
  localparam int         NCH8    = 2;
  localparam int         CW8     = 8;
  localparam logic [9:0] BASE    = 10'h300;
  localparam logic [1:0] BASE_HI = 2'b11;
  localparam longint     MAXC    = (64'd1 << CW) - 1;
`ifdef UP_TPL_PN_CNT_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUTs
  logic            up_clk = 1'b0;
  logic            up_rst;
  logic [NCH-1:0]  pn_err, pn_oos;
  logic [NCH8-1:0] pn_err8, pn_oos8;
  logic            irq, irq8;

  always #5 up_clk = ~up_clk;

  up_tpl_pn_err_cnt_if bus ();
  up_tpl_pn_err_cnt_if bus8 ();

  up_tpl_pn_err_cnt #(.NUM_CHANNELS(NCH), .CNT_WIDTH(CW), .BASE_ADDR(BASE)) dut (
    .up_clk (up_clk), .up_rst (up_rst), .pn_err (pn_err), .pn_oos (pn_oos),
    .up_bus (bus), .irq (irq)
  );

  up_tpl_pn_err_cnt #(.NUM_CHANNELS(NCH8), .CNT_WIDTH(CW8), .BASE_ADDR(BASE)) dut8 (
    .up_clk (up_clk), .up_rst (up_rst), .pn_err (pn_err8), .pn_oos (pn_oos8),
    .up_bus (bus8), .irq (irq8)
  );

  // ---------------- scoreboard state
  int checks   = 0;
  int failures = 0;

  longint   cnt_m  [NCH];
  longint   snap_m [NCH];
  bit       err_m  [NCH];
  bit       oos_m  [NCH];
  bit [1:0] mask_m;
  bit       irq_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit any_err();
    bit r = 1'b0;
    for (int i = 0; i < NCH; i++) r |= err_m[i];
    return r;
  endfunction

  function automatic bit any_oos();
    bit r = 1'b0;
    for (int i = 0; i < NCH; i++) r |= oos_m[i];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [9:0] a);
    logic [7:0]  off;
    logic [31:0] r;
    int          ch;
    off = a[7:0];
    r   = '0;
    if (a[9:8] != BASE_HI) return '0;
    if (off == 8'h00) r = {16'h0001, 8'(CW), 8'(NCH)};
    else if (off == 8'h02) r = {30'b0, any_oos(), any_err()};
    else if (off == 8'h03) r = IRQ_EN ? {30'b0, mask_m} : 32'h0;
    else if (off >= 8'h10 && int'(off) < 16 + 2 * NCH) begin
      ch = (int'(off) - 16) / 2;
      if (off[0] == 1'b0) r = snap_m[ch][31:0];
      else                r = {29'b0, pn_oos[ch], oos_m[ch], err_m[ch]};
    end
    return r;
  endfunction

  // Advance one clock: update the model from what the DUT sees at this edge.
  task automatic step();
    bit         hit_w, irq_n;
    logic [7:0] off;
    logic [1:0] w1c;
    irq_n = |({any_oos(), any_err()} & mask_m);
    hit_w = bus.up_wreq && (bus.up_waddr[9:8] == BASE_HI);
    off   = bus.up_waddr[7:0];
    if (up_rst) begin
      for (int c = 0; c < NCH; c++) begin
        cnt_m[c] = 0; snap_m[c] = 0; err_m[c] = 0; oos_m[c] = 0;
      end
      mask_m = 2'b00;
      irq_m  = 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        w1c = (hit_w && int'(off) == 16 + 2 * c + 1) ? bus.up_wdata[1:0] : 2'b00;
        if (hit_w && off == 8'h01 && bus.up_wdata[0]) snap_m[c] = cnt_m[c];
        if (hit_w && off == 8'h01 && bus.up_wdata[1]) cnt_m[c] = 0;
        else if (pn_err[c] && !pn_oos[c] && cnt_m[c] < MAXC) cnt_m[c]++;
        err_m[c] = pn_err[c] | (err_m[c] & ~w1c[0]);
        oos_m[c] = pn_oos[c] | (oos_m[c] & ~w1c[1]);
      end
      if (IRQ_EN && hit_w && off == 8'h03) mask_m = bus.up_wdata[1:0];
      irq_m = irq_n;
    end
    @(posedge up_clk);
    #1;
    chk("irq", {31'b0, irq}, {31'b0, irq_m});
  endtask

  // ---------------- driver tasks
  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    bus.up_wreq = 1'b1; bus.up_waddr = a; bus.up_wdata = d;
    step();
    chk("wack", {31'b0, bus.up_wack}, {31'b0, a[9:8] == BASE_HI});
    bus.up_wreq = 1'b0;
  endtask

  task automatic rd_exp(input logic [9:0] a, input logic [31:0] exp, input string tag);
    bit hit;
    hit = (a[9:8] == BASE_HI);
    bus.up_rreq = 1'b1; bus.up_raddr = a;
    step();
    chk({tag, "_rack"}, {31'b0, bus.up_rack}, {31'b0, hit});
    chk({tag, "_rdata"}, bus.up_rdata, hit ? exp : 32'h0);
    bus.up_rreq = 1'b0;
    step();
    chk({tag, "_rack_low"}, {31'b0, bus.up_rack}, 32'h0);
  endtask

  task automatic rd(input logic [9:0] a, input string tag);
    rd_exp(a, model_read(a), tag);
  endtask

  task automatic wr8(input logic [9:0] a, input logic [31:0] d);
    bus8.up_wreq = 1'b1; bus8.up_waddr = a; bus8.up_wdata = d;
    step();
    bus8.up_wreq = 1'b0;
  endtask

  task automatic rd8(input logic [9:0] a, input logic [31:0] exp, input string tag);
    bus8.up_rreq = 1'b1; bus8.up_raddr = a;
    step();
    chk({tag, "_rack"}, {31'b0, bus8.up_rack}, 32'h1);
    chk({tag, "_rdata"}, bus8.up_rdata, exp);
    bus8.up_rreq = 1'b0;
    step();
  endtask

  // ---------------- directed + random sequence
  initial begin
    int n;
    logic [9:0] a1, a2;
    logic [31:0] e1, e2;
    up_rst = 1'b1;
    pn_err = '0; pn_oos = '0; pn_err8 = '0; pn_oos8 = '0;
    bus.up_wreq = 0;  bus.up_waddr = '0;  bus.up_wdata = '0;
    bus.up_rreq = 0;  bus.up_raddr = '0;
    bus8.up_wreq = 0; bus8.up_waddr = '0; bus8.up_wdata = '0;
    bus8.up_rreq = 0; bus8.up_raddr = '0;
    repeat (3) step();
    up_rst = 1'b0;
    chk("rst_rack", {31'b0, bus.up_rack}, 32'h0);
    chk("rst_wack", {31'b0, bus.up_wack}, 32'h0);
    chk("rst_rdata", bus.up_rdata, 32'h0);

    rd_exp(10'h300, 32'h0001_2004, "config");

    // ch2: five counted errors
    for (int i = 0; i < 5; i++) begin
      pn_err[2] = 1'b1; step(); pn_err[2] = 1'b0; step();
    end
    wr(10'h301, 32'h1);
    rd_exp(10'h314, 32'd5, "ch2_count");
    rd_exp(10'h310, 32'd0, "ch0_count");
    rd_exp(10'h315, 32'h1, "ch2_flags");

    // ch1: clear+snapshot while errors keep arriving
    pn_err[1] = 1'b1;
    repeat (7) step();
    wr(10'h301, 32'h3);
    pn_err[1] = 1'b0;
    rd_exp(10'h312, 32'd7, "ch1_preclear");
    wr(10'h301, 32'h1);
    rd_exp(10'h312, 32'd0, "ch1_cleared");

    // ch3: errors while out of sync
    pn_oos[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pn_err[3] = 1'b1; step(); pn_err[3] = 1'b0; step();
    end
    wr(10'h301, 32'h1);
    rd_exp(10'h316, 32'd0, "ch3_count_oos");
    rd_exp(10'h317, 32'h7, "ch3_flags");
    wr(10'h317, 32'h3);
    rd_exp(10'h317, 32'h6, "ch3_w1c_oos_wins");
    pn_oos[3] = 1'b0;
    wr(10'h317, 32'h2);
    rd_exp(10'h317, 32'h0, "ch3_flags_clr");
    rd(10'h302, "summary");

    // window boundaries and unused offsets
    rd_exp(10'h3FF, 32'h0, "unused_top");
    rd_exp(10'h000, 32'h0, "non_hit");
    rd_exp(10'h301, 32'h0, "control_ro0");
    rd_exp(10'h318, 32'h0, "ch4_absent");
    wr(10'h000, 32'hFFFF_FFFF);
    rd(10'h303, "mask_default");

    // back-to-back reads
    a1 = 10'h314; a2 = 10'h300;
    e1 = model_read(a1);
    bus.up_rreq = 1'b1; bus.up_raddr = a1;
    step();
    e2 = model_read(a2);
    chk("b2b_first", bus.up_rdata, e1);
    bus.up_raddr = a2;
    step();
    chk("b2b_second", bus.up_rdata, e2);
    chk("b2b_rack", {31'b0, bus.up_rack}, 32'h1);
    bus.up_rreq = 1'b0;
    step();

    // interrupt path (inactive unless the feature is built in)
    for (int c = 0; c < NCH; c++) wr(10'(16'h310 + 2 * c + 1), 32'h3);
    wr(10'h303, 32'h1);
    rd(10'h303, "mask_rd");
    step();
    pn_err[0] = 1'b1; step(); pn_err[0] = 1'b0;
    repeat (3) step();
    wr(10'h311, 32'h1);
    repeat (3) step();

    // random phase
    for (int it = 0; it < 300; it++) begin
      pn_err = 4'($urandom);
      pn_oos = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      case ($urandom_range(0, 7))
        0: wr(10'h301, 32'($urandom_range(0, 3)));
        1: wr(10'(16'h311 + 2 * $urandom_range(0, NCH - 1)), 32'($urandom_range(0, 3)));
        2: rd(10'h300 + 10'($urandom_range(0, 31)), "rand_rd");
        3: wr(10'h303, 32'($urandom_range(0, 3)));
        4: rd(($urandom_range(0, 1) == 0) ? 10'h302 : 10'($urandom_range(0, 767)), "rand_rd2");
        default: step();
      endcase
    end
    pn_err = '0; pn_oos = '0;
    wr(10'h301, 32'h1);
    for (int c = 0; c < NCH; c++) begin
      rd(10'(16'h310 + 2 * c), "final_count");
      rd(10'(16'h311 + 2 * c), "final_flags");
    end
    rd(10'h302, "final_summary");

    // narrow counter instance: count then saturate
    rd8(10'h300, 32'h0001_0802, "cfg8");
    n = $urandom_range(100, 200);
    pn_err8[0] = 1'b1;
    repeat (n) step();
    pn_err8[0] = 1'b0;
    wr8(10'h301, 32'h1);
    rd8(10'h310, 32'(n), "cnt8_partial");
    pn_err8[0] = 1'b1;
    repeat (300) step();
    pn_err8[0] = 1'b0;
    wr8(10'h301, 32'h1);
    rd8(10'h310, 32'd255, "cnt8_sat");
    rd8(10'h312, 32'd0, "cnt8_ch1");
    chk("irq8", {31'b0, irq8}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
